// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad column scanner with debounce and key encoding for the calculator entry path.
// Define AUTO_REPEAT_EN to re-pulse key_valid while keys with codes 1-14 are held.
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter int unsigned DEBOUNCE_CNT  = 4,
  parameter int unsigned REPEAT_DELAY  = 100,
  parameter int unsigned REPEAT_PERIOD = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [4:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state;
  logic [3:0]       row_s1, row_s2;
  logic [DIV_W-1:0] div;
  logic [1:0]       col, row;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             tick, hit, all_high;
  logic [1:0]       hit_row;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
  logic [RPT_W-1:0] rpt, rpt_inc;
  assign rpt_inc = rpt + RPT_W'(1);
`endif

  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] code;
    case ({r, c})
      4'h0: code = 5'd1;   4'h1: code = 5'd2;   4'h2: code = 5'd3;   4'h3: code = 5'd11;
      4'h4: code = 5'd4;   4'h5: code = 5'd5;   4'h6: code = 5'd6;   4'h7: code = 5'd12;
      4'h8: code = 5'd7;   4'h9: code = 5'd8;   4'hA: code = 5'd9;   4'hB: code = 5'd13;
      4'hC: code = 5'd16;  4'hD: code = 5'd10;  4'hE: code = 5'd15;  default: code = 5'd14;
    endcase
    return code;
  endfunction

  // A hit needs exactly one row low; ghosted multi-row patterns count as no key.
  always_comb begin
    hit     = 1'b0;
    hit_row = '0;
    case (row_s2)
      4'b1110: begin hit = 1'b1; hit_row = 2'd0; end
      4'b1101: begin hit = 1'b1; hit_row = 2'd1; end
      4'b1011: begin hit = 1'b1; hit_row = 2'd2; end
      4'b0111: begin hit = 1'b1; hit_row = 2'd3; end
      default: ;
    endcase
  end

  assign all_high = &row_s2;
  assign tick     = (div == DIV_W'(SCAN_DIV - 1));
  assign cnt_inc  = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= SCAN;
      row_s1    <= '1;
      row_s2    <= '1;
      div       <= '0;
      col       <= '0;
      col_n     <= 4'b1110;
      row       <= '0;
      cnt       <= '0;
      key_value <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      row_s1    <= row_n;
      row_s2    <= row_s1;
      key_valid <= 1'b0;
      div       <= tick ? '0 : div + DIV_W'(1);
      if (tick) begin
        case (state)
          SCAN: begin
            if (hit) begin
              row   <= hit_row;
              cnt   <= CNT_W'(1);
              state <= DEBOUNCE;
            end else begin
              col   <= col + 2'd1;
              col_n <= {col_n[2:0], col_n[3]};
            end
          end
          DEBOUNCE: begin
            if (hit && hit_row == row) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                state     <= PRESSED;
                cnt       <= '0;
                key_value <= key_code(row, col);
                key_held  <= 1'b1;
                key_valid <= 1'b1;
`ifdef AUTO_REPEAT_EN
                rpt       <= '0;
`endif
              end
            end else begin
              state <= SCAN;
              cnt   <= '0;
              col   <= col + 2'd1;
              col_n <= {col_n[2:0], col_n[3]};
            end
          end
          PRESSED: begin
            if (all_high) begin
              state <= RELEASE;
              cnt   <= CNT_W'(1);
`ifdef AUTO_REPEAT_EN
              rpt   <= '0;
`endif
            end
`ifdef AUTO_REPEAT_EN
            // Reloading DELAY-PERIOD makes every later repeat land PERIOD ticks apart.
            else if (key_value <= 5'd14) begin
              if (rpt_inc == RPT_W'(REPEAT_DELAY)) begin
                key_valid <= 1'b1;
                rpt       <= RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);
              end else begin
                rpt <= rpt_inc;
              end
            end
`endif
          end
          RELEASE: begin
            if (all_high) begin
              cnt <= cnt_inc;
              if (cnt_inc == CNT_W'(DEBOUNCE_CNT)) begin
                state     <= SCAN;
                cnt       <= '0;
                key_value <= '0;
                key_held  <= 1'b0;
                col       <= col + 2'd1;
                col_n     <= {col_n[2:0], col_n[3]};
              end
            end else if (!row_s2[row]) begin
              state <= PRESSED;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder; a key matrix model drives row_n from col_n.
module tb_keypad_scan_encoder;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row_n, col_n;
  logic [4:0] key_value;
  logic       key_valid, key_held;
  logic [3:0] keys [4];
  int         checks = 0;
  int         errors = 0;

  keypad_scan_encoder #(
    .SCAN_DIV(4), .DEBOUNCE_CNT(3), .REPEAT_DELAY(6), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .row_n(row_n), .col_n(col_n),
    .key_value(key_value), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // keys[r][c] set means the switch at row r / column c is closed
  always_comb begin
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r] & ~col_n);
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (col_n == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_zero(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_value == 5'd0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic watch(input int n, input logic [4:0] exp_val,
                       output int strobes, output int first, output int last, output int bad);
    strobes = 0; first = -1; last = -1; bad = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (key_valid) begin
        strobes++;
        if (first < 0) first = i;
        last = i;
      end
      if (key_value !== exp_val) bad++;
    end
  endtask

  initial begin
    bit ok;
    int s, f, l, b, s_sum, b_sum;
    logic [3:0] rot [3];
    rot[0] = 4'b1011; rot[1] = 4'b0111; rot[2] = 4'b1110;
    for (int r = 0; r < 4; r++) keys[r] = '0;

    // reset and free-running scan
    @(negedge clk); @(negedge clk);
    check("rst_col", col_n, 4'b1110);
    check("rst_value", key_value, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("dwell_col0", col_n, 4'b1110);
    @(negedge clk);
    check("rot_col1", col_n, 4'b1101);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      check("rot_col", col_n, rot[i]);
    end

    // row1/col1 press: accept exactly 12 clocks after col1 becomes active
    keys[1][1] = 1'b1;
    wait_col(4'b1101, 20, ok);
    check("wait_col1", ok, 1);
    repeat (11) @(negedge clk);
    check("pre_accept", key_valid, 0);
    @(negedge clk);
    check("accept_valid", key_valid, 1);
    check("accept_value", key_value, 5);
    check("accept_held", key_held, 1);
    watch(20, 5'd5, s, f, l, b);
    check("single_strobe", s, 0);
    check("hold_value", b, 0);
    check("frozen_col", col_n, 4'b1101);
    keys[1][1] = 1'b0;
    wait_zero(24, ok);
    check("release", ok, 1);
    check("release_held", key_held, 0);
    check("release_rot", col_n, 4'b1011);

    // bounce on row2/col2
    s_sum = 0; b_sum = 0;
    for (int i = 0; i < 6; i++) begin
      keys[2][2] = (i % 2 == 0);
      watch(4, 5'd0, s, f, l, b);
      s_sum += s; b_sum += b;
    end
    keys[2][2] = 1'b0;
    check("bounce_strobe", s_sum, 0);
    check("bounce_value", b_sum, 0);
    wait_col(4'b1110, 40, ok);
    check("bounce_scan", ok, 1);

    // rows 0 and 3 on col0 together
    keys[0][0] = 1'b1; keys[3][0] = 1'b1;
    wait_col(4'b1110, 40, ok);
    check("multi_wait", ok, 1);
    watch(8, 5'd0, s, f, l, b);
    check("multi_strobe", s, 0);
    check("multi_value", b, 0);
    check("multi_scan", col_n, 4'b1011);
    keys[0][0] = 1'b0; keys[3][0] = 1'b0;

    // row3/col1 -> digit 0 (10)
    keys[3][1] = 1'b1;
    wait_valid(60, ok);
    check("k10_valid", ok, 1);
    check("k10_value", key_value, 10);
    keys[3][1] = 1'b0;
    wait_zero(24, ok);
    check("k10_release", ok, 1);

    // row3/col2 -> enter (15), never repeats
    keys[3][2] = 1'b1;
    wait_valid(60, ok);
    check("k15_valid", ok, 1);
    check("k15_value", key_value, 15);
    watch(60, 5'd15, s, f, l, b);
    check("k15_no_repeat", s, 0);
    check("k15_hold", b, 0);
    keys[3][2] = 1'b0;
    wait_zero(24, ok);
    check("k15_release", ok, 1);

    // row0/col0 held: repeats only when the feature is built in
    keys[0][0] = 1'b1;
    wait_valid(60, ok);
    check("k1_valid", ok, 1);
    check("k1_value", key_value, 1);
    watch(50, 5'd1, s, f, l, b);
`ifdef AUTO_REPEAT_EN
    check("rpt_count", s, 4);
    check("rpt_first", f, 24);
    check("rpt_last", l, 48);
`else
    check("rpt_none", s, 0);
`endif
    check("k1_hold", b, 0);
    keys[0][0] = 1'b0;
    wait_zero(24, ok);
    check("k1_release", ok, 1);

    // reset while clear (16) is held, then re-acceptance
    keys[3][0] = 1'b1;
    wait_valid(60, ok);
    check("k16_valid", ok, 1);
    check("k16_value", key_value, 16);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_value", key_value, 0);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_col", col_n, 4'b1110);
    check("mid_rst_valid", key_valid, 0);
    reset_n = 1'b1;
    repeat (11) @(negedge clk);
    check("re_pre_accept", key_valid, 0);
    @(negedge clk);
    check("re_accept_valid", key_valid, 1);
    check("re_accept_value", key_value, 16);
    watch(30, 5'd16, s, f, l, b);
    check("re_single", s, 0);
    check("re_hold", b, 0);
    keys[3][0] = 1'b0;
    wait_zero(24, ok);
    check("k16_release", ok, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
